msx_wait_gen: RTL and testbench
===============================

# msx_wait_gen

Parametrised Z80 wait-state generator for the MSX core. It generalises the fixed one-wait M1 flip-flop pair into a counter-based engine, with independent wait counts for opcode fetch (M1), I/O, and memory cycles, plus an external wait input and an optional turbo bypass. It sits between the T80 bus outputs and the CPU `WAIT_n` pin, clocked by `clk21m` and advanced by the 3.58 MHz CPU clock enable.

## Interface
Parameters:
- `CNT_W`, 4: width of the wait counter. Every `*_WAITS` value must be ≤ 2**CNT_W−1.
- `M1_WAITS`, 1: wait states inserted in M1 cycles (opcode fetch and interrupt acknowledge).
- `IO_WAITS`, 0: wait states inserted in I/O cycles (`iorq_n`=0, `m1_n`=1).
- `MEM_WAITS`, 0: wait states inserted in non-M1, non-refresh memory cycles.

Ports:
- `clk21m`  in  1  system clock, 21.477 MHz.
- `reset`  in  1  reset, asynchronous, active-high.
- `ce_3m58_p`  in  1  CPU-clock positive-phase enable; all state changes happen only on `clk21m` edges where this is 1.
- `m1_n`, `mreq_n`, `iorq_n`, `rfsh_n`  in  1 each  T80 bus status, active-low.
- `exwait_n`  in  1  external wait request (cartridge/slot), synchronous to `clk21m`, active-low.
- `turbo`  in  1  turbo request; only effective with `WAIT_TURBO_EN`.
- `wait_n`  out  1  to T80 `WAIT_n`.
- `busy`  out  1  high while an internal wait count is running.
- `wait_cnt`  out  CNT_W  current counter value (debug).

## Operation
- Output is `wait_n = wait_int_n & exwait_n`. The `exwait_n` term is combinational, so external waits extend any cycle, including IDLE.
- Cycle start: at a `ce_3m58_p` edge in IDLE where (`mreq_n`=0 or `iorq_n`=0) and `rfsh_n`=1.
- Classification at cycle start, evaluated in this order:
  - `m1_n`=0 → `M1_WAITS`
  - `iorq_n`=0 → `IO_WAITS`
  - otherwise → `MEM_WAITS`
- Refresh cycles (`rfsh_n`=0) never start a count.
- State machine: IDLE, COUNT, DONE.
  - IDLE → COUNT if N>0: set `wait_int_n`←0 and `cnt`←N.
  - IDLE → DONE if N=0: `wait_int_n` stays 1.
  - COUNT: on each `ce_3m58_p`, `cnt`←`cnt`−1. When `cnt`=1 at that edge, `wait_int_n`←1, `cnt`←0, go to DONE.
  - COUNT abort: if `mreq_n` and `iorq_n` are both 1 at a `ce_3m58_p` edge, go to IDLE with `wait_int_n`←1 and `cnt`←0.
  - DONE: when `mreq_n` and `iorq_n` are both 1 at a `ce_3m58_p` edge, go to IDLE. No new count starts in the same cycle.
- N is sampled once, at cycle start. A later `turbo` change does not affect a running count.
- `busy` = (state == COUNT).

## Timing
- Reset values: `wait_n`=`exwait_n` (internal 1), `busy`=0, `wait_cnt`=0, state IDLE. Reset applies immediately, including mid-COUNT.
- `wait_n` is low for exactly N `ce_3m58_p` periods: from the start edge k to edge k+N. This is N Tw states on the T80.
- With `M1_WAITS`=1, behaviour is identical to the legacy one-wait M1 generator.
- Latency from cycle start to `wait_n` falling: one `clk21m` cycle after the `ce_3m58_p` edge.
- Simultaneous `exwait_n`=0 and internal expiry: `wait_n` stays 0 until `exwait_n` rises. The internal count still expires on schedule (no extra internal waits).
- A `ce_3m58_p` edge with no enable pulse since reset leaves the state held; no spurious starts.

## Configuration
- `WAIT_TURBO_EN` defined: while `turbo`=1 at cycle start, N is forced to 0 for every class. `exwait_n` is still honoured.
- `WAIT_TURBO_EN` undefined: the `turbo` port is ignored and the turbo logic is not synthesised.

## Test plan
- Defaults, M1 fetch (`m1_n`=`mreq_n`=0) → `wait_n` low for exactly 1 `ce_3m58_p` period, `busy`=1 for that period, state DONE until `mreq_n` rises.
- `MEM_WAITS`=3, memory read with `m1_n`=1 → `wait_n` low for 3 CE periods; `wait_cnt` reads 3, 2, 1, then 0.
- `IO_WAITS`=2 with `exwait_n` held low 5 CE periods from cycle start → `wait_n` low for 5 periods; `busy` drops after 2.
- Refresh cycle (`mreq_n`=0, `rfsh_n`=0) with `MEM_WAITS`=4 → `wait_n` stays 1, `busy` stays 0.
- `reset` asserted mid-COUNT with `cnt`=2 → `wait_n`=1, `busy`=0, `wait_cnt`=0 without waiting for a clock edge; the next M1 after release produces a normal 1-wait cycle.
- `WAIT_TURBO_EN` defined, `turbo`=1, `M1_WAITS`=2 → no internal wait. `turbo` raised mid-COUNT → the count completes its full 2 periods.

Source files
------------

// File: rtl/msx_wait_gen.sv
// Counter-based Z80 WAIT_n generator with per-class (M1/IO/MEM) wait counts.
// Optional turbo bypass is built only when WAIT_TURBO_EN is defined.
module msx_wait_gen #(
  parameter int CNT_W     = 4,
  parameter int M1_WAITS  = 1,
  parameter int IO_WAITS  = 0,
  parameter int MEM_WAITS = 0
) (
  input  logic             clk21m,
  input  logic             reset,
  input  logic             ce_3m58_p,
  input  logic             m1_n,
  input  logic             mreq_n,
  input  logic             iorq_n,
  input  logic             rfsh_n,
  input  logic             exwait_n,
  input  logic             turbo,
  output logic             wait_n,
  output logic             busy,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [CNT_W-1:0] N_M1  = CNT_W'(M1_WAITS);
  localparam logic [CNT_W-1:0] N_IO  = CNT_W'(IO_WAITS);
  localparam logic [CNT_W-1:0] N_MEM = CNT_W'(MEM_WAITS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state;
  logic             wait_int_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_cls;
  logic [CNT_W-1:0] n_sel;
  logic             bus_idle;
  logic             start;

  assign bus_idle = mreq_n & iorq_n;
  assign start    = ~bus_idle & rfsh_n;

  // M1 wins over IORQ so interrupt acknowledge uses the M1 count
  always_comb begin
    n_cls = N_MEM;
    if (!m1_n)
      n_cls = N_M1;
    else if (!iorq_n)
      n_cls = N_IO;
  end

`ifdef WAIT_TURBO_EN
  assign n_sel = turbo ? '0 : n_cls;
`else
  logic unused_turbo;
  assign unused_turbo = turbo;
  assign n_sel        = n_cls;
`endif

  always_ff @(posedge clk21m or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wait_int_n <= 1'b1;
      cnt        <= '0;
    end else if (ce_3m58_p) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (n_sel != '0) begin
              state      <= COUNT;
              wait_int_n <= 1'b0;
              cnt        <= n_sel;
            end else begin
              state <= DONE;
            end
          end
        end
        COUNT: begin
          if (bus_idle) begin
            state      <= IDLE;
            wait_int_n <= 1'b1;
            cnt        <= '0;
          end else if (cnt <= ONE) begin
            state      <= DONE;
            wait_int_n <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        DONE: begin
          if (bus_idle)
            state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          wait_int_n <= 1'b1;
          cnt        <= '0;
        end
      endcase
    end
  end

  assign wait_n   = wait_int_n & exwait_n;
  assign busy     = (state == COUNT);
  assign wait_cnt = cnt;

endmodule

// File: tb/tb_msx_wait_gen.sv
// Randomised bus-cycle bench for msx_wait_gen (M1=1, IO=2, MEM=3 waits).
// Expected waits come from "low for the first min(N, cycle length) CE periods".
`timescale 1ns/1ps
module tb_msx_wait_gen;

  logic       clk21m = 1'b0;
  logic       reset;
  logic       ce_3m58_p;
  logic       m1_n, mreq_n, iorq_n, rfsh_n;
  logic       exwait_n;
  logic       turbo;
  logic       wait_n;
  logic       busy;
  logic [3:0] wait_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  msx_wait_gen #(
    .CNT_W    (4),
    .M1_WAITS (1),
    .IO_WAITS (2),
    .MEM_WAITS(3)
  ) dut (
    .clk21m   (clk21m),
    .reset    (reset),
    .ce_3m58_p(ce_3m58_p),
    .m1_n     (m1_n),
    .mreq_n   (mreq_n),
    .iorq_n   (iorq_n),
    .rfsh_n   (rfsh_n),
    .exwait_n (exwait_n),
    .turbo    (turbo),
    .wait_n   (wait_n),
    .busy     (busy),
    .wait_cnt (wait_cnt)
  );

  always #5 clk21m = ~clk21m;

  // One CPU clock period: five idle clocks, then one clock with the enable
  task automatic step();
    repeat (5) @(negedge clk21m);
    ce_3m58_p = 1'b1;
    @(negedge clk21m);
    ce_3m58_p = 1'b0;
  endtask

  task automatic bus_off();
    m1_n   = 1'b1;
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    rfsh_n = 1'b1;
  endtask

  // Bus cycle held for len CE edges, then released for one edge
  task automatic txn(input string nm, input bit m1, input bit io,
                     input bit rf, input int len, input int ex_lo,
                     input bit t0, input bit t1);
    int         n;
    bit         exp_int;
    logic [3:0] exp_c;
    n = rf ? 0 : (m1 ? 1 : (io ? 2 : 3));
`ifdef WAIT_TURBO_EN
    if (t0) n = 0;
`endif
    m1_n   = !m1;
    iorq_n = !io;
    mreq_n = io;
    rfsh_n = !rf;
    turbo  = t0;
    for (int j = 0; j < len; j++) begin
      if (j > 0) turbo = t1;
      exwait_n = (j < ex_lo) ? 1'b0 : 1'b1;
      step();
      exp_int = (j >= n);
      exp_c   = (j < n) ? 4'(n - j) : 4'd0;
      n_chk++;
      if (wait_n !== (exp_int & exwait_n)) begin
        n_fail++;
        $display("FAIL %s wait_n j=%0d got %b exp %b", nm, j, wait_n,
                 exp_int & exwait_n);
      end
      n_chk++;
      if (busy !== !exp_int) begin
        n_fail++;
        $display("FAIL %s busy j=%0d got %b exp %b", nm, j, busy, !exp_int);
      end
      n_chk++;
      if (wait_cnt !== exp_c) begin
        n_fail++;
        $display("FAIL %s wait_cnt j=%0d got %0d exp %0d", nm, j, wait_cnt,
                 exp_c);
      end
    end
    bus_off();
    exwait_n = 1'b1;
    turbo    = 1'b0;
    step();
    n_chk++;
    if (wait_n !== 1'b1 || busy !== 1'b0 || wait_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL %s release got w=%b b=%b c=%0d exp w=1 b=0 c=0", nm,
               wait_n, busy, wait_cnt);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ce_3m58_p = 1'b0;
    exwait_n  = 1'b1;
    turbo     = 1'b0;
    bus_off();
    repeat (3) @(negedge clk21m);
    reset = 1'b0;
    @(negedge clk21m);
    n_chk++;
    if (wait_n !== 1'b1 || busy !== 1'b0 || wait_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_state got w=%b b=%b c=%0d exp w=1 b=0 c=0",
               wait_n, busy, wait_cnt);
    end
    exwait_n = 1'b0;
    #1;
    n_chk++;
    if (wait_n !== 1'b0) begin
      n_fail++;
      $display("FAIL exwait_idle got %b exp 0", wait_n);
    end
    exwait_n = 1'b1;
  endtask

  task automatic test_no_ce();
    m1_n   = 1'b0;
    mreq_n = 1'b0;
    repeat (12) @(negedge clk21m);
    n_chk++;
    if (wait_n !== 1'b1 || busy !== 1'b0 || wait_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL no_ce got w=%b b=%b c=%0d exp w=1 b=0 c=0",
               wait_n, busy, wait_cnt);
    end
    bus_off();
    step();
  endtask

  task automatic test_reset_mid_count();
    m1_n   = 1'b1;
    mreq_n = 1'b0;
    step();
    step();
    n_chk++;
    if (wait_cnt !== 4'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset got c=%0d b=%b exp c=2 b=1", wait_cnt, busy);
    end
    reset = 1'b1;
    #1;
    n_chk++;
    if (wait_n !== 1'b1 || busy !== 1'b0 || wait_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL async_reset got w=%b b=%b c=%0d exp w=1 b=0 c=0",
               wait_n, busy, wait_cnt);
    end
    bus_off();
    @(negedge clk21m);
    reset = 1'b0;
    step();
    txn("m1_after_reset", 1, 0, 0, 3, 0, 0, 0);
  endtask

  task automatic test_random();
    bit m1, io, rf;
    int len;
    for (int i = 0; i < 40; i++) begin
      m1  = ($urandom_range(0, 2) == 0);
      io  = ($urandom_range(0, 2) == 0);
      rf  = !m1 && !io && ($urandom_range(0, 3) == 0);
      len = $urandom_range(1, 6);
      txn("random", m1, io, rf, len, $urandom_range(0, len),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_no_ce();
    txn("m1_fetch", 1, 0, 0, 3, 0, 0, 0);
    txn("int_ack", 1, 1, 0, 3, 0, 0, 0);
    txn("mem_read", 0, 0, 0, 5, 0, 0, 0);
    txn("io_exwait", 0, 1, 0, 6, 5, 0, 0);
    txn("refresh", 0, 0, 1, 5, 0, 0, 0);
    txn("mem_abort", 0, 0, 0, 2, 0, 0, 0);
    test_reset_mid_count();
    txn("turbo_m1", 1, 0, 0, 3, 0, 1, 1);
    txn("turbo_mem", 0, 0, 0, 4, 0, 1, 1);
    txn("turbo_mid", 0, 0, 0, 5, 0, 0, 1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
